// File: rtl/note_scheduler.sv
// Chart-driven ball launcher: fetches gap/end entries from a synchronous ROM,
// launches one ball per entry, judges its flight and keeps saturating HUD statistics.
module note_scheduler #(
  parameter int ADDR_W      = 8,
  parameter int SCORE_W     = 16,
  parameter int PERFECT_PTS = 100,
  parameter int FLIGHT_MAX  = 255
) (
  input  logic               frame_clk,
  input  logic               Reset,
  input  logic               start,
  output logic [ADDR_W-1:0]  chart_addr,
  input  logic [7:0]         chart_data,
  input  logic               ball_keep_on,
  input  logic               ball_perfect_f,
  input  logic               ball_miss_f,
  output logic               BallEN,
  output logic [SCORE_W-1:0] score,
  output logic [7:0]         combo,
  output logic [7:0]         hits,
  output logic [7:0]         misses,
  output logic               busy,
  output logic               done
);

  localparam int FT_W = $clog2(FLIGHT_MAX + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, LOAD, WAIT, LAUNCH, ARM, FLIGHT, JUDGE, DONE
  } state_t;

  state_t          state;
  logic [6:0]      gap_cnt;
  logic [FT_W-1:0] flight_cnt;
  logic            perf_seen, miss_seen, timeout;
  logic            timer_hit;
  logic [SCORE_W:0] score_sum;

  // Last ARM/FLIGHT frame of the allowed window.
  assign timer_hit = (flight_cnt == FT_W'(FLIGHT_MAX - 1));

  always_comb begin
    score_sum = {1'b0, score} + (SCORE_W+1)'(PERFECT_PTS);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state      <= IDLE;
      chart_addr <= '0;
      score      <= '0;
      combo      <= '0;
      hits       <= '0;
      misses     <= '0;
      BallEN     <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      gap_cnt    <= '0;
      flight_cnt <= '0;
      perf_seen  <= 1'b0;
      miss_seen  <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      BallEN <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            score      <= '0;
            combo      <= '0;
            hits       <= '0;
            misses     <= '0;
            chart_addr <= '0;
            busy       <= 1'b1;
            done       <= 1'b0;
            state      <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          if (chart_data[7]) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            gap_cnt <= chart_data[6:0];
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (gap_cnt == 7'd0) begin
            BallEN <= 1'b1;
            state  <= LAUNCH;
          end else begin
            gap_cnt <= gap_cnt - 7'd1;
          end
        end
        LAUNCH: begin
          perf_seen  <= 1'b0;
          miss_seen  <= 1'b0;
          timeout    <= 1'b0;
          flight_cnt <= '0;
          state      <= ARM;
        end
        ARM: begin
          if (timer_hit) begin
            timeout <= 1'b1;
            state   <= JUDGE;
          end else begin
            flight_cnt <= flight_cnt + 1'b1;
            if (ball_keep_on) state <= FLIGHT;
          end
        end
        FLIGHT: begin
          perf_seen <= perf_seen | ball_perfect_f;
          miss_seen <= miss_seen | ball_miss_f;
          if (timer_hit) begin
            timeout <= 1'b1;
            state   <= JUDGE;
          end else begin
            flight_cnt <= flight_cnt + 1'b1;
            if (!ball_keep_on) state <= JUDGE;
          end
        end
        JUDGE: begin
          // Anything short of a clean perfect (miss flag, untouched ball, timeout) is a miss.
          if (perf_seen && !timeout) begin
            hits  <= (&hits)  ? hits  : hits  + 8'd1;
            combo <= (&combo) ? combo : combo + 8'd1;
            score <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
          end else begin
            misses <= (&misses) ? misses : misses + 8'd1;
            combo  <= '0;
          end
          if (&chart_addr) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            chart_addr <= chart_addr + 1'b1;
            state      <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: launch timing, judging, timeout, reset, restart
// and saturation (second instance with a larger point value).
module tb_note_scheduler;

  logic        clk;
  logic        Reset, start;
  logic [7:0]  chart_addr, chart_data;
  logic        ball_keep_on, ball_perfect_f, ball_miss_f;
  logic        BallEN, busy, done;
  logic [15:0] score;
  logic [7:0]  combo, hits, misses;

  logic        start_s;
  logic [7:0]  chart_addr_s, chart_data_s;
  logic        keep_s, perf_s, miss_s;
  logic        ballen_s, busy_s, done_s;
  logic [15:0] score_s;
  logic [7:0]  combo_s, hits_s, misses_s;

  logic [7:0]  rom [0:255];
  int          n_vec = 0;
  int          n_err = 0;

  note_scheduler dut (
    .frame_clk(clk), .Reset(Reset), .start(start), .chart_addr(chart_addr),
    .chart_data(chart_data), .ball_keep_on(ball_keep_on), .ball_perfect_f(ball_perfect_f),
    .ball_miss_f(ball_miss_f), .BallEN(BallEN), .score(score), .combo(combo),
    .hits(hits), .misses(misses), .busy(busy), .done(done)
  );

  note_scheduler #(.PERFECT_PTS(262)) dut_sat (
    .frame_clk(clk), .Reset(Reset), .start(start_s), .chart_addr(chart_addr_s),
    .chart_data(chart_data_s), .ball_keep_on(keep_s), .ball_perfect_f(perf_s),
    .ball_miss_f(miss_s), .BallEN(ballen_s), .score(score_s), .combo(combo_s),
    .hits(hits_s), .misses(misses_s), .busy(busy_s), .done(done_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_ff @(posedge clk) chart_data <= rom[chart_addr];

  // Always-perfect ball for the saturation instance; its chart is all gap-0 entries.
  initial begin
    int cnt;
    cnt = 0;
    keep_s = 1'b0; perf_s = 1'b0; miss_s = 1'b0; chart_data_s = 8'h00;
    forever begin
      @(negedge clk);
      if (ballen_s) cnt = 3;
      else if (cnt > 0) cnt--;
      keep_s = (cnt > 0);
      perf_s = (cnt > 0) && (cnt < 3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", tag, got, exp);
    end
  endtask

  task automatic wait_launch();
    int n = 0;
    while (!BallEN && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("launch_seen", 32'(BallEN), 1);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 32'(done), 1);
  endtask

  task automatic kick();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Ball busy for LAUNCH..FLIGHT, flags visible in the one FLIGHT frame; returns once stats settle.
  task automatic play_ball(input bit perf, input bit miss, input bit stray);
    wait_launch();
    ball_keep_on = 1'b1; ball_miss_f = stray;
    @(negedge clk);
    ball_perfect_f = perf; ball_miss_f = miss;
    @(negedge clk);
    @(negedge clk);
    ball_keep_on = 1'b0; ball_perfect_f = 1'b0; ball_miss_f = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic timeout_ball(input bit keep, input int miss_before, input bit next_launch);
    wait_launch();
    ball_keep_on = keep;
    @(negedge clk);
    ball_perfect_f = keep;
    repeat (254) @(negedge clk);
    @(negedge clk);
    chk("to_not_early", 32'(misses), 32'(miss_before));
    ball_keep_on = 1'b0; ball_perfect_f = 1'b0;
    @(negedge clk);
    chk("to_misses", 32'(misses), 32'(miss_before + 1));
    chk("to_combo", 32'(combo), 0);
    repeat (3) @(negedge clk);
    chk("to_next_launch", 32'(BallEN), 32'(next_launch));
  endtask

  initial begin
    Reset = 1'b1; start = 1'b0; start_s = 1'b0;
    ball_keep_on = 1'b0; ball_perfect_f = 1'b0; ball_miss_f = 1'b0;
    for (int i = 0; i < 256; i++) rom[i] = 8'h80;
    repeat (3) @(negedge clk);
    chk("rst_ballen", 32'(BallEN), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_score", 32'(score), 0);
    chk("rst_addr", 32'(chart_addr), 0);
    Reset = 1'b0;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 0);

    // Gap 2, then end: launch exactly at frame 6, perfect judged at frame 22.
    rom[0] = 8'h02; rom[1] = 8'h80;
    start = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      @(negedge clk);
      if (k <= 10) chk($sformatf("t1_ballen_f%0d", k), 32'(BallEN), 32'(k == 6));
      if (k == 1) chk("t1_busy", 32'(busy), 1);
      if (k == 22) chk("t1_hits_pre", 32'(hits), 0);
      start = 1'b0;
      ball_keep_on = (k >= 7 && k <= 20);
      ball_perfect_f = (k >= 12 && k <= 20);
    end
    chk("t1_hits", 32'(hits), 1);
    chk("t1_combo", 32'(combo), 1);
    chk("t1_score", 32'(score), 100);
    chk("t1_done", 32'(done), 1);
    chk("t1_busy_end", 32'(busy), 0);

    // Restart from DONE; perfect, perfect, miss with a start pulse while busy.
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h80;
    kick();
    chk("t2_clr_hits", 32'(hits), 0);
    chk("t2_clr_score", 32'(score), 0);
    chk("t2_clr_combo", 32'(combo), 0);
    chk("t2_clr_addr", 32'(chart_addr), 0);
    chk("t2_clr_done", 32'(done), 0);
    play_ball(1'b1, 1'b0, 1'b0);
    chk("t2_combo1", 32'(combo), 1);
    start = 1'b1;
    play_ball(1'b1, 1'b0, 1'b0);
    start = 1'b0;
    chk("t2_combo2", 32'(combo), 2);
    chk("t2_addr_busy_start", 32'(chart_addr), 2);
    play_ball(1'b0, 1'b1, 1'b0);
    chk("t2_combo3", 32'(combo), 0);
    wait_done();
    chk("t2_hits", 32'(hits), 2);
    chk("t2_misses", 32'(misses), 1);
    chk("t2_score", 32'(score), 200);

    // Stray flag outside FLIGHT ignored; untouched ball counts as a miss.
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h80;
    kick();
    play_ball(1'b1, 1'b0, 1'b1);
    chk("t3_misses0", 32'(misses), 0);
    chk("t3_hits", 32'(hits), 1);
    play_ball(1'b0, 1'b0, 1'b0);
    chk("t3_misses1", 32'(misses), 1);
    chk("t3_combo", 32'(combo), 0);
    chk("t3_score", 32'(score), 100);
    wait_done();

    // Timeouts: ball never arrives, then ball stuck in flight with a perfect flag.
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h00; rom[3] = 8'h80;
    kick();
    play_ball(1'b1, 1'b0, 1'b0);
    chk("t4_combo1", 32'(combo), 1);
    timeout_ball(1'b0, 0, 1'b1);
    timeout_ball(1'b1, 1, 1'b0);
    chk("t4_hits", 32'(hits), 1);
    chk("t4_score", 32'(score), 100);
    wait_done();

    // Reset mid-flight and during a launch frame.
    rom[0] = 8'h00; rom[1] = 8'h00; rom[2] = 8'h80;
    kick();
    play_ball(1'b1, 1'b0, 1'b0);
    chk("t5_hits_pre", 32'(hits), 1);
    wait_launch();
    ball_keep_on = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t5_busy_flight", 32'(busy), 1);
    Reset = 1'b1;
    #1;
    chk("t5_ballen", 32'(BallEN), 0);
    chk("t5_busy", 32'(busy), 0);
    chk("t5_score", 32'(score), 0);
    chk("t5_hits", 32'(hits), 0);
    chk("t5_combo", 32'(combo), 0);
    chk("t5_misses", 32'(misses), 0);
    chk("t5_addr", 32'(chart_addr), 0);
    ball_keep_on = 1'b0;
    @(negedge clk);
    Reset = 1'b0;
    @(negedge clk);
    chk("t5_idle_busy", 32'(busy), 0);
    chk("t5_idle_done", 32'(done), 0);
    rom[0] = 8'h00; rom[1] = 8'h80;
    kick();
    wait_launch();
    Reset = 1'b1;
    #1;
    chk("t5_launch_rst", 32'(BallEN), 0);
    @(negedge clk);
    Reset = 1'b0;

    // Saturation: 256 perfects at 262 points; stops at the last address without wrapping.
    start_s = 1'b1;
    @(negedge clk);
    start_s = 1'b0;
    begin
      int n = 0;
      while (hits_s != 8'd250 && n < 3000) begin
        @(negedge clk);
        n++;
      end
      chk("t6_hits250", 32'(hits_s), 250);
      chk("t6_score_pre", 32'(score_s), 65500);
      n = 0;
      while (!done_s && n < 200) begin
        @(negedge clk);
        n++;
      end
      chk("t6_done", 32'(done_s), 1);
    end
    chk("t6_score_sat", 32'(score_s), 65535);
    chk("t6_hits_sat", 32'(hits_s), 255);
    chk("t6_combo_sat", 32'(combo_s), 255);
    chk("t6_misses", 32'(misses_s), 0);
    chk("t6_addr", 32'(chart_addr_s), 255);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
